// File: rtl/serializer_5bit_tx_pkg.sv
// rtl/serializer_5bit_tx_pkg.sv - shared word/counter widths, state encoding and default words
//
// Purpose: common definitions for the 5-bit serial transmitter.
//   WORD_W / CNT_W            : word width and bit-counter width
//   state_e                   : one-hot INIT / TRAIN / DATA encoding
//   DEF_TRAIN_PATTERN         : single-one alignment marker sent after reset
//   DEF_IDLE_WORD             : filler word when nothing is buffered
package serializer_5bit_tx_pkg;

  localparam int WORD_W = 5;
  localparam int CNT_W  = 3;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [CNT_W-1:0]  bit_cnt_t;

  typedef enum logic [2:0] {
    ST_INIT  = 3'b001,
    ST_TRAIN = 3'b010,
    ST_DATA  = 3'b100
  } state_e;

  localparam word_t    DEF_TRAIN_PATTERN = 5'b10000;
  localparam word_t    DEF_IDLE_WORD     = 5'b00000;

  // Bit counter value while the last (LSB) bit of a word is on the line.
  localparam bit_cnt_t LAST_BIT = 3'd4;

endpackage

// File: rtl/serializer_5bit_tx_if.sv
// rtl/serializer_5bit_tx_if.sv - word input handshake of the serial transmitter
//
// Purpose: groups the valid/ready word interface.
//   data_i  : word to transmit, bit 4 goes out first
//   valid_i : data_i is valid
//   ready_o : transmitter can take a word this cycle
// Modports: master = word source, slave = transmitter.
interface serializer_5bit_tx_if;
  import serializer_5bit_tx_pkg::*;

  word_t data_i;
  logic  valid_i;
  logic  ready_o;

  modport master (output data_i, output valid_i, input ready_o);
  modport slave  (input data_i, input valid_i, output ready_o);

endinterface

// File: rtl/serializer_5bit_tx.sv
// rtl/serializer_5bit_tx.sv - 5-bit MSB-first serializer with training and idle fill
//
// Purpose: accepts 5-bit words, buffers one, and shifts each out MSB-first at
// one bit per clock. After reset TRAIN_WORDS copies of TRAIN_PATTERN are sent,
// then data words, with IDLE_WORD filling any gap so the line never stalls.
// Ports:
//   clk          : clock, all state on the rising edge
//   reset        : synchronous active-high reset
//   in_if        : word handshake (slave side: data_i, valid_i in, ready_o out)
//   serial_o     : serial line bit (shift register MSB)
//   word_start_o : high while serial_o carries bit 4 of a word
//   train_o      : high for every bit of a training word
//   idle_o       : high for every bit of an inserted idle word
module serializer_5bit_tx
  import serializer_5bit_tx_pkg::*;
#(
  parameter int    TRAIN_WORDS   = 16,
  parameter word_t TRAIN_PATTERN = DEF_TRAIN_PATTERN,
  parameter word_t IDLE_WORD     = DEF_IDLE_WORD
) (
  input  logic                  clk,
  input  logic                  reset,
  serializer_5bit_tx_if.slave   in_if,
  output logic                  serial_o,
  output logic                  word_start_o,
  output logic                  train_o,
  output logic                  idle_o
);

  localparam int WCNT_W = (TRAIN_WORDS > 1) ? $clog2(TRAIN_WORDS) : 1;
  localparam logic [WCNT_W-1:0] LAST_TRAIN = WCNT_W'(TRAIN_WORDS - 1);

  state_e            state_q, state_d;
  word_t             shift_q, shift_d;
  bit_cnt_t          bit_cnt_q, bit_cnt_d;
  logic [WCNT_W-1:0] word_cnt_q, word_cnt_d;
  word_t             buf_q, buf_d;
  logic              buf_valid_q, buf_valid_d;
  logic              word_start_q, word_start_d;
  logic              train_q, train_d;
  logic              idle_q, idle_d;

  logic ready;
  logic handshake;
  logic boundary;
  logic load_next;

  assign ready     = (state_q != ST_INIT) && !buf_valid_q;
  assign handshake = in_if.valid_i && ready;
  assign boundary  = (bit_cnt_q == LAST_BIT);

  always_comb begin
    state_d      = state_q;
    shift_d      = {shift_q[WORD_W-2:0], 1'b0};
    bit_cnt_d    = boundary ? '0 : bit_cnt_t'(bit_cnt_q + 1'b1);
    word_cnt_d   = word_cnt_q;
    buf_d        = buf_q;
    buf_valid_d  = buf_valid_q;
    word_start_d = 1'b0;
    train_d      = train_q;
    idle_d       = idle_q;
    load_next    = 1'b0;

    case (state_q)
      ST_INIT: begin
        shift_d      = TRAIN_PATTERN;
        bit_cnt_d    = '0;
        word_cnt_d   = '0;
        word_start_d = 1'b1;
        train_d      = 1'b1;
        idle_d       = 1'b0;
        state_d      = ST_TRAIN;
      end
      ST_TRAIN: begin
        if (boundary) begin
          if (word_cnt_q == LAST_TRAIN) begin
            load_next = 1'b1;
            state_d   = ST_DATA;
          end else begin
            shift_d      = TRAIN_PATTERN;
            word_cnt_d   = WCNT_W'(word_cnt_q + 1'b1);
            word_start_d = 1'b1;
          end
        end
      end
      ST_DATA: begin
        load_next = boundary;
      end
      default: begin
        // Unreachable encodings fall back to a clean restart.
        state_d = ST_INIT;
      end
    endcase

    // Word boundary into (or within) DATA: buffered word, then bypass, then idle.
    if (load_next) begin
      word_start_d = 1'b1;
      train_d      = 1'b0;
      if (buf_valid_q) begin
        shift_d     = buf_q;
        buf_valid_d = 1'b0;
        idle_d      = 1'b0;
      end else if (handshake) begin
        shift_d = in_if.data_i;
        idle_d  = 1'b0;
      end else begin
        shift_d = IDLE_WORD;
        idle_d  = 1'b1;
      end
    end

    // A handshake that did not go straight onto the line parks in the buffer.
    // ready is low whenever the buffer is full, so this never overwrites it.
    if (handshake && !load_next) begin
      buf_d       = in_if.data_i;
      buf_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_INIT;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      word_cnt_q   <= '0;
      buf_q        <= '0;
      buf_valid_q  <= 1'b0;
      word_start_q <= 1'b0;
      train_q      <= 1'b0;
      idle_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      word_cnt_q   <= word_cnt_d;
      buf_q        <= buf_d;
      buf_valid_q  <= buf_valid_d;
      word_start_q <= word_start_d;
      train_q      <= train_d;
      idle_q       <= idle_d;
    end
  end

  assign in_if.ready_o = ready;
  assign serial_o      = shift_q[WORD_W-1];
  assign word_start_o  = word_start_q;
  assign train_o       = train_q;
  assign idle_o        = idle_q;

endmodule

// File: tb/tb_serializer_5bit_tx.sv
// tb/tb_serializer_5bit_tx.sv - self-checking bench for serializer_5bit_tx
module tb_serializer_5bit_tx;
  import serializer_5bit_tx_pkg::*;

  localparam int          TW = 16;
  localparam logic [4:0]  TP = 5'b10000;
  localparam logic [4:0]  IW = 5'b00000;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic serial_o, word_start_o, train_o, idle_o;

  serializer_5bit_tx_if bus ();

  serializer_5bit_tx #(
    .TRAIN_WORDS   (TW),
    .TRAIN_PATTERN (TP),
    .IDLE_WORD     (IW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_if        (bus),
    .serial_o     (serial_o),
    .word_start_o (word_start_o),
    .train_o      (train_o),
    .idle_o       (idle_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       valid;
    logic [4:0] data;
    logic       exp_serial;
    logic       exp_ws;
    logic       exp_train;
    logic       exp_idle;
    logic       exp_ready;
  } vec_t;

  vec_t vecs [12];

  int n_vec = 0;
  int n_bad = 0;

  logic [4:0] exp_q [$];
  bit         mon_en      = 1'b0;
  bit         in_word     = 1'b0;
  int         bit_idx     = 0;
  logic [4:0] cur_bits    = '0;
  logic       cur_train   = 1'b0;
  logic       cur_idle    = 1'b0;
  bit         cur_has     = 1'b0;
  logic [4:0] cur_exp     = '0;
  int         trains_seen = 0;
  int         idle_seen   = 0;
  int         data_seen   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic eval_word();
    if (cur_train) begin
      chk("train_word", 32'(cur_bits), 32'(TP));
      chk("train_excess", 32'(trains_seen < TW), 32'd1);
      trains_seen++;
    end else begin
      chk("train_count", 32'(trains_seen), 32'(TW));
      if (cur_has) begin
        chk("data_word", 32'({cur_idle, cur_bits}), 32'({1'b0, cur_exp}));
        data_seen++;
      end else begin
        chk("idle_word", 32'({cur_idle, cur_bits}), 32'({1'b1, IW}));
        idle_seen++;
      end
    end
  endtask

  // Scoreboard sample, taken 1 time unit after each rising edge.
  task automatic mon_sample();
    if (!mon_en) begin
      in_word     = 1'b0;
      bit_idx     = 0;
      trains_seen = 0;
      exp_q.delete();
      return;
    end
    if (word_start_o || !in_word || bit_idx == 5) begin
      if (in_word) chk("word_period", 32'(bit_idx), 32'd5);
      chk("word_start", 32'(word_start_o), 32'd1);
      in_word   = 1'b1;
      bit_idx   = 0;
      cur_bits  = '0;
      cur_train = train_o;
      cur_idle  = idle_o;
      cur_has   = 1'b0;
      // A data word is owed whenever something was accepted but not yet sent.
      if (!train_o && exp_q.size() > 0) begin
        cur_has = 1'b1;
        cur_exp = exp_q.pop_front();
      end
    end
    chk("flag_align", 32'({train_o, idle_o}), 32'({cur_train, cur_idle}));
    cur_bits = {cur_bits[3:0], serial_o};
    bit_idx++;
    if (bit_idx == 5) eval_word();
  endtask

  task automatic step(input logic r, input logic v, input logic [4:0] d, output bit hs);
    reset       = r;
    bus.valid_i = v;
    bus.data_i  = d;
    #1;
    hs = !r && v && bus.ready_o;
    if (hs && mon_en) exp_q.push_back(d);
    @(posedge clk);
    #1;
    mon_sample();
    @(negedge clk);
  endtask

  task automatic wait_ws();
    bit hs;
    int n = 0;
    do begin
      step(1'b0, 1'b0, 5'd0, hs);
      n++;
    end while (!word_start_o && n < 20);
    chk("wait_ws_timeout", 32'(word_start_o), 32'd1);
  endtask

  initial begin
    bit         hs;
    int         n;
    int         d0, i0;
    logic [4:0] burst [4];

    burst = '{5'h01, 5'h1F, 5'h0A, 5'h15};

    //           rst   val   data       ser   ws    trn   idl   rdy
    vecs[0]  = '{1'b1, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 5'b00000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 5'b00000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 5'b10110, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 5'b00000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    bus.valid_i = 1'b0;
    bus.data_i  = '0;

    // Reset, start of training, and a word accepted during training.
    for (int i = 0; i < 12; i++) begin
      if (!vecs[i].rst) mon_en = 1'b1;
      step(vecs[i].rst, vecs[i].valid, vecs[i].data, hs);
      chk($sformatf("vec%0d", i),
          32'({serial_o, word_start_o, train_o, idle_o, bus.ready_o}),
          32'({vecs[i].exp_serial, vecs[i].exp_ws, vecs[i].exp_train,
               vecs[i].exp_idle, vecs[i].exp_ready}));
    end

    // Finish training: the buffered word goes first, then idle fill.
    repeat (100) step(1'b0, 1'b0, 5'd0, hs);
    chk("first_data_words", 32'(data_seen), 32'd1);
    chk("idle_words", 32'(idle_seen), 32'd5);

    // Sustained stream with valid held high.
    d0 = data_seen;
    for (int w = 0; w < 4; w++) begin
      n = 0;
      do begin
        step(1'b0, 1'b1, burst[w], hs);
        n++;
      end while (!hs && n < 20);
      chk($sformatf("burst%0d_accept", w), 32'(hs), 32'd1);
    end
    i0 = idle_seen;
    repeat (25) step(1'b0, 1'b0, 5'd0, hs);
    chk("burst_words", 32'(data_seen - d0), 32'd4);

    // Bypass: word offered exactly on a boundary edge with the buffer empty.
    wait_ws();
    repeat (4) step(1'b0, 1'b0, 5'd0, hs);
    chk("bypass_ready_before", 32'(bus.ready_o), 32'd1);
    step(1'b0, 1'b1, 5'b11001, hs);
    chk("bypass_accept", 32'(hs), 32'd1);
    chk("bypass_latency", 32'({serial_o, word_start_o, idle_o, bus.ready_o}), 32'b1101);
    repeat (10) step(1'b0, 1'b0, 5'd0, hs);

    // Reset mid-word with the buffer full: buffered word must never appear.
    wait_ws();
    step(1'b0, 1'b1, 5'b01110, hs);
    chk("buffer_accept", 32'(hs), 32'd1);
    chk("buffer_full_ready", 32'(bus.ready_o), 32'd0);
    mon_en = 1'b0;
    d0 = data_seen;
    i0 = idle_seen;
    step(1'b1, 1'b0, 5'd0, hs);
    chk("midreset_outputs",
        32'({serial_o, word_start_o, train_o, idle_o, bus.ready_o}), 32'd0);
    mon_en = 1'b1;
    step(1'b0, 1'b0, 5'd0, hs);
    chk("retrain_first_bit", 32'({serial_o, word_start_o, train_o, idle_o}), 32'b1110);
    repeat (100) step(1'b0, 1'b0, 5'd0, hs);
    chk("retrain_no_data", 32'(data_seen - d0), 32'd0);
    chk("retrain_idle", 32'(idle_seen - i0), 32'd4);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
